// File: rtl/mem_stage_pkg.sv
// Shared constants and helpers for the MEM stage: ALU op codes, bus types, FSM states.
// Optional misalignment trap is enabled by MEM_MISALIGN_TRAP_EN (see mem_stage.sv).
package mem_stage_pkg;

    typedef logic [7:0]  alu_op_t;
    typedef logic [31:0] reg_t;
    typedef logic [4:0]  reg_addr_t;

    localparam reg_t      ZERO_WORD     = 32'h0000_0000;
    localparam logic      WRITE_DISABLE = 1'b0;
    localparam reg_addr_t NOP_REG_ADDR  = 5'd0;

    localparam alu_op_t EXE_LB_OP  = 8'b1110_0000;
    localparam alu_op_t EXE_LH_OP  = 8'b1110_0001;
    localparam alu_op_t EXE_LW_OP  = 8'b1110_0011;
    localparam alu_op_t EXE_LBU_OP = 8'b1110_0100;
    localparam alu_op_t EXE_LHU_OP = 8'b1110_0101;
    localparam alu_op_t EXE_SB_OP  = 8'b1110_1000;
    localparam alu_op_t EXE_SH_OP  = 8'b1110_1001;
    localparam alu_op_t EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_e;

    function automatic logic is_load(alu_op_t op);
        return op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP};
    endfunction

    function automatic logic is_store(alu_op_t op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    // Access size in bytes; only meaningful for memory ops.
    function automatic logic [2:0] access_bytes(alu_op_t op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 3'd1;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 3'd2;
            default:                          return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide shared RAM port between the MEM stage (master) and the RAM arbiter (slave).
interface mem_stage_if #(parameter int ADDR_W = 32);
    logic              ce;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic              gnt;
    logic [7:0]        rdata;

    modport master (output ce, we, addr, wdata, input gnt, rdata);
    modport slave  (input ce, we, addr, wdata, output gnt, rdata);
endinterface

// File: rtl/mem_load_ext.sv
// Size/sign extension of the assembled load bytes according to the load op.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  alu_op_t aluop,
    input  reg_t    acc,
    output reg_t    data
);
    always_comb begin
        data = acc;
        case (aluop)
            EXE_LB_OP:  data = {{24{acc[7]}}, acc[7:0]};
            EXE_LBU_OP: data = {24'd0, acc[7:0]};
            EXE_LH_OP:  data = {{16{acc[15]}}, acc[15:0]};
            EXE_LHU_OP: data = {16'd0, acc[15:0]};
            default:    data = acc;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: ALU results pass through; loads/stores run byte-serially on a shared RAM port.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses (adds the misalign output).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MAX_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  reg_addr_t         mem_wd,
    input  logic              mem_wreg,
    input  reg_t              mem_wdata,
    input  alu_op_t           mem_aluop,
    input  logic [ADDR_W-1:0] mem_addr,
    input  reg_t              mem_sdata,
    input  logic              stall_wb,
    output reg_addr_t         wb_wd,
    output logic              wb_wreg,
    output reg_t              wb_wdata,
    output logic              stallreq,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    mem_stage_if.master       ram
);
    localparam int CNT_W = $clog2(MAX_BYTES);

    mem_state_e                 state, state_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt, cnt_last;
    logic [MAX_BYTES-1:0][7:0]  acc, acc_nxt;
    logic [MAX_BYTES-1:0][7:0]  sbytes;
    logic                       mem_op, store, last;
    reg_t                       ld_data;

    assign sbytes   = mem_sdata;
    assign store    = is_store(mem_aluop);
    assign mem_op   = is_load(mem_aluop) | store;
    assign cnt_last = CNT_W'(access_bytes(mem_aluop) - 3'd1);
    assign last     = (cnt == cnt_last);

    mem_load_ext u_ext (
        .aluop (mem_aluop),
        .acc   (acc),
        .data  (ld_data)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q, mis_nxt, mis_now;
    assign mis_now = (access_bytes(mem_aluop) == 3'd2 && mem_addr[0]) ||
                     (access_bytes(mem_aluop) == 3'd4 && mem_addr[1:0] != 2'b00);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MEM_IDLE;
            cnt   <= '0;
            acc   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q <= mis_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        wb_wd     = NOP_REG_ADDR;
        wb_wreg   = WRITE_DISABLE;
        wb_wdata  = ZERO_WORD;
        stallreq  = 1'b0;
        ram.ce    = 1'b0;
        ram.we    = 1'b0;
        ram.addr  = '0;
        ram.wdata = 8'd0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_nxt   = mis_q;
        misalign  = 1'b0;
`endif
        case (state)
            MEM_IDLE: begin
                if (!mem_op) begin
                    wb_wd    = mem_wd;
                    wb_wreg  = mem_wreg;
                    wb_wdata = mem_wdata;
                end else begin
                    stallreq  = 1'b1;
                    cnt_nxt   = '0;
                    acc_nxt   = '0;
                    state_nxt = MEM_REQ;
`ifdef MEM_MISALIGN_TRAP_EN
                    mis_nxt = mis_now;
                    if (mis_now) state_nxt = MEM_DONE;
`endif
                end
            end
            MEM_REQ: begin
                // Request stays stable until granted; addr wraps naturally at ADDR_W.
                stallreq  = 1'b1;
                ram.ce    = 1'b1;
                ram.we    = store;
                ram.addr  = mem_addr + ADDR_W'(cnt);
                ram.wdata = sbytes[cnt];
                if (ram.gnt) begin
                    if (!store)    state_nxt = MEM_WAIT;
                    else if (last) state_nxt = MEM_DONE;
                    else           cnt_nxt   = cnt + 1'b1;
                end
            end
            MEM_WAIT: begin
                stallreq     = 1'b1;
                acc_nxt[cnt] = ram.rdata;
                if (last) begin
                    state_nxt = MEM_DONE;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = MEM_REQ;
                end
            end
            MEM_DONE: begin
                wb_wd    = mem_wd;
                wb_wreg  = mem_wreg;
                wb_wdata = store ? mem_wdata : ld_data;
`ifdef MEM_MISALIGN_TRAP_EN
                if (mis_q) begin
                    misalign = 1'b1;
                    wb_wreg  = WRITE_DISABLE;
                end
`endif
                if (!stall_wb) state_nxt = MEM_IDLE;
            end
            default: state_nxt = MEM_IDLE;
        endcase

        if (rst) begin
            wb_wd     = NOP_REG_ADDR;
            wb_wreg   = WRITE_DISABLE;
            wb_wdata  = ZERO_WORD;
            stallreq  = 1'b0;
            ram.ce    = 1'b0;
            ram.we    = 1'b0;
            ram.addr  = '0;
            ram.wdata = 8'd0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign  = 1'b0;
`endif
        end
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline, between the ex_mem and mem_wb pipeline registers.
- Non-memory instructions pass through combinationally.
- Loads and stores run over a shared byte-wide RAM port, one byte per access, under an FSM.
- Raises stallreq to ctrl until the access completes.

Parameters:
- ADDR_W, 32, byte address width; address arithmetic wraps modulo 2^ADDR_W.
- MAX_BYTES, 4, largest access size in bytes (word).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_wd  in  5  destination register from ex_mem
- mem_wreg  in  1  write enable from ex_mem
- mem_wdata  in  32  ALU result from ex_mem
- mem_aluop  in  8  op code (EXE_LB/LH/LW/LBU/LHU/SB/SH/SW_OP; anything else is non-memory)
- mem_addr  in  32  effective address
- mem_sdata  in  32  store data (rs2)
- stall_wb  in  1  stall[4] from ctrl (mem_wb held)
- wb_wd  out  5  destination register to mem_wb
- wb_wreg  out  1  write enable to mem_wb
- wb_wdata  out  32  result to mem_wb
- stallreq  out  1  stall request to ctrl
- ram_ce  out  1  RAM request
- ram_we  out  1  RAM write (1) / read (0)
- ram_addr  out  32  byte address
- ram_wdata  out  8  store byte
- ram_gnt  in  1  arbiter grant, same cycle as ram_ce
- ram_rdata  in  8  read byte, valid the cycle after a granted read

Behaviour:
- While rst is high, all outputs read 0, FSM goes to IDLE, and the byte counter clears to 0. Reset mid-access abandons the access; no partial write-back occurs.
- FSM states: IDLE, REQ, WAIT, DONE. Byte counter cnt is 2 bits; accumulator acc is 32 bits.
- Access size n: 1 for B/BU, 2 for H/HU, 4 for W.
- IDLE, non-memory op:
  - wb_* = mem_* combinationally; stallreq = 0; zero latency.
- IDLE, memory op:
  - stallreq = 1 in the same cycle.
  - Next state REQ; cnt = 0; acc = 0.
- REQ:
  - ram_ce = 1, ram_addr = mem_addr + cnt, ram_we = 1 for a store.
  - ram_wdata = mem_sdata byte[cnt].
  - Without ram_gnt: stay in REQ, all request signals held stable.
- REQ, granted store:
  - If cnt = n-1, go to DONE; else cnt+1 and stay in REQ.
- REQ, granted load: go to WAIT.
- WAIT:
  - ram_ce = 0; acc byte[cnt] = ram_rdata.
  - If cnt = n-1, go to DONE; else cnt+1 and go to REQ.
- DONE:
  - stallreq = 0; wb_wd = mem_wd; wb_wreg = mem_wreg.
  - wb_wdata is the load result: LB/LH sign-extended from bit 7/15, LBU/LHU zero-extended, LW = acc. For a store, wb_wdata = mem_wdata.
  - Go to IDLE at the next edge unless stall_wb = 1; in that case stay in DONE with outputs held.
- stallreq = 1 in IDLE (memory op), REQ and WAIT.
- Latency with ram_gnt tied high:
  - Load: 1 + 2n stall cycles, then 1 DONE cycle.
  - Store: 1 + n stall cycles, then 1 DONE cycle.
- Misaligned addresses are legal; bytes are taken little-endian. Address wraps past 0xFFFFFFFF to 0.
- A load to x0 still performs the RAM access; the write is suppressed downstream via wb_wreg/wd as given.
- Inputs are assumed stable from IDLE through DONE, since ctrl holds ex_mem while stallreq is high.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- When defined:
  - Extra output misalign, 1 bit, reset 0.
  - An H access with addr[0] != 0, or a W access with addr[1:0] != 0, goes from IDLE directly to DONE with no RAM request.
  - In DONE, misalign = 1 and wb_wreg = 0.
- When undefined: no port exists, and misaligned accesses proceed byte-serially.

Decomposition:
- defines.vh holds the shared constants: EXE_*_OP codes, AluOpBus, RegBus, RegAddrBus, ZeroWord, WriteDisable, NOPRegAddr, and the FSM state encodings (MEM_IDLE, MEM_REQ, MEM_WAIT, MEM_DONE).
- One natural sub-module, mem_load_ext: combinational size/sign extension of acc by aluop.

Test Plan:
- ALU op, mem_wdata=0xDEADBEEF, wd=5, wreg=1 -> same cycle wb_wdata=0xDEADBEEF, wb_wd=5, wb_wreg=1, stallreq=0, ram_ce=0.
- LW addr 0x100, RAM bytes 0x11,0x22,0x33,0x44, gnt=1 -> ram_addr 0x100..0x103, stallreq high 9 cycles, then DONE wb_wdata=0x44332211.
- LB addr 0x203 byte 0x80 -> wb_wdata=0xFFFFFF80; LBU same byte -> 0x00000080; LH addr 0x0 bytes 0x34,0xF2 -> 0xFFFFF234.
- SH addr 0x301, sdata=0x0000ABCD, gnt low 3 cycles then high -> request held steady; writes 0xCD@0x301 then 0xAB@0x302; stallreq high 1+3+2=6 cycles.
- LW addr 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; stall_wb=1 for 2 cycles in DONE -> outputs held, then IDLE.
- rst asserted in WAIT of an LW -> next cycle all outputs 0, state IDLE; with rst deasserted the held LW restarts at cnt=0.
